cond_sum_adder_pipe: RTL

// - Parametrised, pipelined conditional-sum (carry-select) adder/subtractor with valid/ready handshake.
// - Operands split into BLK-bit blocks; each block computes sum for carry-in 0 and 1, and the real carry selects one.
// - Block groups are spread over STAGES register stages, with the carry registered between groups.
// - Next generation of the 64-bit registered carry-select adder: width, block size and depth are generic; it adds a subtract mode, signed overflow and back-pressure.

---
 rtl/cond_sum_adder_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cond_sum_adder_pipe.sv
// Pipelined conditional-sum adder/subtractor with valid/ready handshake.
// Carry-select blocks are grouped per stage; the group carry is registered.
module cond_sum_adder_pipe #(
   parameter int WIDTH  = 64,
   parameter int BLK    = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NB = WIDTH / BLK;
   localparam int G  = NB / STAGES;
   localparam int L  = STAGES - 1;

   if (BLK < 2 || (WIDTH % BLK) != 0 || STAGES < 1 ||
       (NB % STAGES) != 0) begin : g_bad
      $error("cond_sum_adder_pipe: bad WIDTH/BLK/STAGES");
   end

   // x holds finished sum bits below the stage boundary and
   // untouched A bits above it; y carries the effective B.
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] ok;
   logic [WIDTH-1:0]  x_q [STAGES];
   logic [WIDTH-1:0]  y_q [STAGES];
   logic [STAGES-1:0] c_q;
   logic              ovf_q;

   logic [WIDTH-1:0]  x_n [STAGES];
   logic [WIDTH-1:0]  y_n [STAGES];
   logic [STAGES-1:0] c_n;
   logic              ovf_n;

   // Stage k may load when it is empty or its successor frees it.
   always_comb begin
      ok = '0;
      ok[L] = !v_q[L] || out_ready;
      for (int k = L - 1; k >= 0; k--) begin
         ok[k] = !v_q[k] || ok[k+1];
      end
   end

   // Per-stage conditional-sum of this stage's block group.
   always_comb begin
      logic [WIDTH-1:0] xi;
      logic [WIDTH-1:0] yi;
      logic             ci;
      logic [BLK:0]     s0;
      logic [BLK:0]     s1;
      int               lo;
      int               p;
      xi    = '0;
      yi    = '0;
      ci    = 1'b0;
      s0    = '0;
      s1    = '0;
      lo    = 0;
      p     = 0;
      ovf_n = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         p = (k > 0) ? k - 1 : 0;
         if (k == 0) begin
            xi = a;
            yi = sub ? ~b : b;
            ci = sub | cin;
         end else begin
            xi = x_q[p];
            yi = y_q[p];
            ci = c_q[p];
         end
         x_n[k] = xi;
         y_n[k] = yi;
         for (int j = 0; j < G; j++) begin
            lo = (k * G + j) * BLK;
            s0 = {1'b0, xi[lo +: BLK]} + {1'b0, yi[lo +: BLK]};
            s1 = {1'b0, xi[lo +: BLK]} + {1'b0, yi[lo +: BLK]}
                 + (BLK+1)'(1);
            x_n[k][lo +: BLK] = ci ? s1[BLK-1:0] : s0[BLK-1:0];
            ci = ci ? s1[BLK] : s0[BLK];
         end
         c_n[k] = ci;
         if (k == L) begin
            ovf_n = (xi[WIDTH-1] == yi[WIDTH-1]) &&
                    (x_n[k][WIDTH-1] != xi[WIDTH-1]);
         end
      end
   end

   // Stage registers; a stalled stage holds everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q   <= '0;
         c_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            x_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (ok[k]) begin
               v_q[k] <= (k == 0) ? in_valid : v_q[(k > 0) ? k - 1 : 0];
               x_q[k] <= x_n[k];
               y_q[k] <= y_n[k];
               c_q[k] <= c_n[k];
               if (k == L) ovf_q <= ovf_n;
            end
         end
      end
   end

   assign in_ready  = ok[0];
   assign out_valid = v_q[L];
   assign sum       = x_q[L];
   assign cout      = c_q[L];
   assign ovf       = ovf_q;

endmodule
